axi4stream_output_arbiter: RTL

//  Shares one axi4stream_output_buffer serializer between NUM_REQ wide-buffer producers (upscaler line/tile engines).

---
 rtl/axi4stream_pkg.sv | 20 ++
 rtl/axi4stream_output_arbiter_rr_arbiter_next.sv | 43 ++++
 rtl/axi4stream_output_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/axi4stream_pkg.sv
// ---------------------------------------------------------------------------
// axi4stream_pkg
//   Shared definitions for the AXI4-Stream output path: the grant FSM state
//   encoding and a counter-width helper that never returns zero bits.
// ---------------------------------------------------------------------------
package axi4stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        ACK    = 2'd2
    } arb_state_e;

    // Width of a counter that must hold values 0..n-1. $clog2(1) is 0, which
    // would give a zero-width vector, so clamp to at least one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi4stream_output_arbiter_rr_arbiter_next.sv
// ---------------------------------------------------------------------------
// rr_arbiter_next
//   Combinational round-robin pick. Starting one past the last granted index
//   and wrapping, returns the first requester with its request bit set.
// Ports:
//   i_req      in  NUM_REQ  request vector
//   i_last_idx in  IDX_W    index granted most recently
//   o_winner   out IDX_W    next index to grant (only meaningful if o_any_req)
//   o_any_req  out 1        at least one request is pending
// ---------------------------------------------------------------------------
module rr_arbiter_next #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_idx,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any_req
);

    int               w_sum;
    logic [IDX_W-1:0] w_sel;

    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        o_winner  = i_last_idx;
        o_any_req = |i_req;
        w_sum     = 0;
        w_sel     = '0;
        // Scan from the farthest offset down to the nearest one: the last
        // assignment wins, so the nearest requester after i_last_idx is
        // chosen without needing a "found" flag.
        for (int off = NUM_REQ; off >= 1; off--) begin
            w_sum = int'(i_last_idx) + off;
            w_sel = IDX_W'(w_sum % NUM_REQ);
            if (i_req[w_sel]) begin
                o_winner = w_sel;
            end
        end
    end

endmodule

// File: rtl/axi4stream_output_arbiter.sv
// ---------------------------------------------------------------------------
// axi4stream_output_arbiter
//   Shares one output serializer among NUM_REQ wide-buffer producers. Grants
//   round-robin, latches the winner's buffer, holds it while the serializer
//   streams NUM_TXN_PER_GRANT transactions (counted by snooping tlast
//   handshakes), then pulses req_ack for that requester for one cycle.
//   Only snoops the downstream handshake; never drives it.
// Ports:
//   aclk, areset       clock; async active-low reset
//   en                 allow new grants (sampled only while idle)
//   req_valid          per-requester buffer valid
//   req_buffer         packed buffers, requester i at [i*BUFFER_WIDTH +: BUFFER_WIDTH]
//   req_ack            one-cycle pulse when requester's grant has completed
//   out_buffer         latched buffer to the serializer
//   out_buffer_valid   serializer input valid
//   mon_tvalid/tready/tlast  snooped downstream AXI handshake
//   busy               grant in progress
//   grant_idx          current / most recent grant
//   protocol_err       sticky: tlast seen at the wrong beat count
// ---------------------------------------------------------------------------
module axi4stream_output_arbiter
    import axi4stream_pkg::*;
#(
    parameter int NUM_REQ           = 4,
    parameter int BUFFER_WIDTH      = 80,
    parameter int BEATS_PER_TXN     = 10,
    parameter int NUM_TXN_PER_GRANT = 1
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            en,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*BUFFER_WIDTH-1:0] req_buffer,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic [BUFFER_WIDTH-1:0]         out_buffer,
    output logic                            out_buffer_valid,
    input  logic                            mon_tvalid,
    input  logic                            mon_tready,
    input  logic                            mon_tlast,
    output logic                            busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_idx,
    output logic                            protocol_err
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = cnt_width(BEATS_PER_TXN);
    localparam int TXN_W  = cnt_width(NUM_TXN_PER_GRANT + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_TXN - 1);
    localparam logic [TXN_W-1:0]  LAST_TXN  = TXN_W'(NUM_TXN_PER_GRANT - 1);

    arb_state_e              r_state;
    arb_state_e              w_next_state;
    logic [BUFFER_WIDTH-1:0] r_out_buffer;
    logic                    r_out_valid;
    logic [IDX_W-1:0]        r_grant_idx;
    logic [BEAT_W-1:0]       r_beat_cnt;
    logic [TXN_W-1:0]        r_txn_cnt;
    logic                    r_protocol_err;

    logic                    w_beat;
    logic                    w_last;
    logic                    w_final_last;
    logic                    w_grant;
    logic                    w_any_req;
    logic [IDX_W-1:0]        w_winner;
    logic [NUM_REQ-1:0]      w_req_ack;

    assign w_beat       = mon_tvalid & mon_tready;
    assign w_last       = w_beat & mon_tlast;
    // tlast handshake that closes the final transaction of this grant
    assign w_final_last = (r_state == STREAM) && w_last && (r_txn_cnt == LAST_TXN);
    assign w_grant      = (r_state == IDLE) && en && w_any_req;

    rr_arbiter_next #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter_next (
        .i_req      (req_valid),
        .i_last_idx (r_grant_idx),
        .o_winner   (w_winner),
        .o_any_req  (w_any_req)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_req_ack    = '0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_next_state = STREAM;
                end
            end
            STREAM: begin
                if (w_final_last) begin
                    w_next_state = ACK;
                end
            end
            ACK: begin
                w_req_ack[r_grant_idx] = 1'b1;
                w_next_state           = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // NOTE: the wide out_buffer register is reset as well, so the serializer
    // never sees stale data from an aborted grant after reset.
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            r_out_buffer   <= '0;
            r_out_valid    <= 1'b0;
            r_grant_idx    <= IDX_W'(NUM_REQ - 1);  // requester 0 wins first
            r_beat_cnt     <= '0;
            r_txn_cnt      <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_out_buffer <= req_buffer[int'(w_winner)*BUFFER_WIDTH +: BUFFER_WIDTH];
                        r_out_valid  <= 1'b1;
                        r_grant_idx  <= w_winner;
                        r_beat_cnt   <= '0;
                        r_txn_cnt    <= '0;
                    end
                end
                STREAM: begin
                    if (w_last) begin
                        if (r_beat_cnt != LAST_BEAT) begin
                            r_protocol_err <= 1'b1;
                        end
                        r_beat_cnt <= '0;
                        r_txn_cnt  <= r_txn_cnt + TXN_W'(1);
                        if (w_final_last) begin
                            r_out_valid <= 1'b0;
                        end
                    end else if (w_beat && (r_beat_cnt != LAST_BEAT)) begin
                        // Saturate rather than wrap when tlast never arrives.
                        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ack          = w_req_ack;
    assign out_buffer       = r_out_buffer;
    assign out_buffer_valid = r_out_valid;
    assign busy             = (r_state != IDLE);
    assign grant_idx        = r_grant_idx;
    assign protocol_err     = r_protocol_err;

endmodule
